cdb_arb: RTL
============

# cdb_arb

Common-data-bus arbiter for the out-of-order core. Each cycle it grants up to `CDB_WIDTH` completing functional-unit requesters a CDB slot, chosen in round-robin order. It registers the winners' physical and architectural tags onto the six-lane CDB. The CDB drives the map table, the reservation stations and the ROB, so `cdb_broadcast`, `cdb_pr_tag0..5` and `cdb_ar_tag0..5` here are the exact signals those consumers take.

## Interface
Parameters:
- `N_REQ`, 8: number of functional-unit requesters; legal range 2..16.
- `CDB_WIDTH`, 6: CDB lanes. Fixed at 6; the port list is written for 6.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `recover` in 1: branch-mispredict / exception flush.
- `fu_req` in N_REQ: requester i has a completed result waiting.
- `fu_pr_tags` in 7*N_REQ: destination PR of requester i, at bits [7i+6:7i].
- `fu_ar_tags` in 5*N_REQ: destination AR of requester i, at bits [5i+4:5i].
- `fu_gnt` out N_REQ: requester i won a lane this cycle (combinational).
- `cdb_broadcast` out 6: lane k valid (registered).
- `cdb_pr_tag0..5` out 7 each: lane PR tags (registered).
- `cdb_ar_tag0..5` out 5 each: lane AR tags (registered).
- `cdb_count` out 3: number of valid lanes, 0..6 (registered).

## Operation
- State:
  - `rr_ptr` (log2 N_REQ bits): highest-priority requester.
  - Output lane registers.
- Priority order is `rr_ptr`, `rr_ptr+1`, ..., `rr_ptr+N_REQ-1`, all mod N_REQ.
- Selection: the first min(6, popcount(`fu_req`)) requesters in priority order are granted.
- `fu_gnt` is a pure function of `fu_req`, `rr_ptr` and `recover`. It never depends on the tag inputs.
- Lane packing:
  - The j-th granted requester in priority order goes to lane j.
  - Valid lanes are always contiguous from lane 0. `cdb_broadcast` is one of 000000, 000001, 000011, ..., 111111.
- Unused lanes:
  - `cdb_broadcast` bit is 0.
  - `cdb_pr_tag` is driven to 7'd0 and `cdb_ar_tag` to 5'd0, so outputs are deterministic.
- `cdb_count` equals popcount(`cdb_broadcast`).
- Round-robin update:
  - When at least one grant occurs, `rr_ptr` <= (index of the last granted requester + 1) mod N_REQ.
  - With zero grants, `rr_ptr` holds.
  - Any requester that keeps requesting is therefore granted within ceil(N_REQ/6)+1 cycles.
- Requester handshake:
  - Requester i holds `fu_req[i]` and its tags stable until it sees `fu_gnt[i]`=1 in the same cycle.
  - In the next cycle it either deasserts or presents a new result.
  - Requests that are not granted are not queued inside the arbiter; the requester retries.
- Recover:
  - While `recover`=1: `fu_gnt` is all-zero, the next lane registers are cleared (`cdb_broadcast`=0, `cdb_count`=0, tags 0), and `rr_ptr` holds.
  - A broadcast registered in the cycle before `recover` still appears during the `recover` cycle. Consumers discard it.
- Reset: `rr_ptr`=0, `cdb_broadcast`=0, all tags 0, `cdb_count`=0. `fu_gnt` is all-zero while `reset`=1.
- Precedence: `reset` beats `recover`, which beats normal arbitration.
- Tags are passed through unchanged. The arbiter does not filter AR 31 or PR 0; consumers handle those.

## Timing
- Grant latency: 0 cycles. `fu_gnt` is valid in the same cycle that `fu_req` is presented.
- Broadcast latency: 1 cycle. Winners in cycle t appear on the CDB for exactly cycle t+1.
- Each lane is valid for a single cycle, with no hold. If there are no grants in t, then `cdb_broadcast`=0 in t+1.
- Throughput: 6 results per cycle sustained.
- Simultaneous events:
  - A requester granted in cycle t may request again in t+1 with new tags and competes normally.
  - `reset` or `recover` asserted mid-burst kills the next cycle's broadcast. No partial lane set is ever produced.

## Test plan
- Reset: assert `reset` 2 cycles with `fu_req`=8'hFF. Required: `fu_gnt`=0; `cdb_broadcast`=0, `cdb_count`=0 and `rr_ptr`=0 in every reset cycle and the cycle after.
- Light load: `rr_ptr`=0, `fu_req`=8'b0010_0101, PR tags 10/20/30 on requesters 0/2/5. Required:
  - `fu_gnt`=8'b0010_0101.
  - Next cycle `cdb_broadcast`=6'b000111, lanes 0/1/2 = PR 10/20/30, `cdb_count`=3.
  - `rr_ptr`=6.
- Saturation and fairness: all 8 requesters request continuously from `rr_ptr`=0. Required:
  - Cycle 1 grants 0..5 on lanes 0..5, then `rr_ptr`=6.
  - Cycle 2 grants 6,7,0,1,2,3 on lanes 0..5, then `rr_ptr`=4.
  - No requester waits more than 3 cycles.
- Wrap packing: `rr_ptr`=6, `fu_req`=8'b1100_0001. Required: lanes 0/1/2 = requesters 6/7/0, then `rr_ptr`=1.
- Recover: grants in cycle t, `recover`=1 in t+1 with `fu_req`=8'hFF. Required:
  - The cycle-t winners broadcast in t+1.
  - `fu_gnt`=0 in t+1.
  - `cdb_broadcast`=0 in t+2.
  - `rr_ptr` is unchanged across the `recover` cycle.
- Idle hold: `fu_req`=0 for 5 cycles after a grant. Required: `cdb_broadcast`=0 from the second cycle on, and `rr_ptr` constant.

Source files
------------

// File: rtl/cdb_arb_if.sv
// Bundle between the completing functional units, the arbiter and the CDB consumers.
// Carries request/tag inputs, combinational grants, and the registered six-lane CDB.
// The modports separate the arbiter side from the requester/consumer side.
interface cdb_arb_if #(
    parameter int N_REQ = 8
);
    logic [N_REQ-1:0]   fu_req;
    logic [7*N_REQ-1:0] fu_pr_tags;
    logic [5*N_REQ-1:0] fu_ar_tags;
    logic [N_REQ-1:0]   fu_gnt;
    logic [5:0]         cdb_broadcast;
    logic [6:0]         cdb_pr_tag0;
    logic [6:0]         cdb_pr_tag1;
    logic [6:0]         cdb_pr_tag2;
    logic [6:0]         cdb_pr_tag3;
    logic [6:0]         cdb_pr_tag4;
    logic [6:0]         cdb_pr_tag5;
    logic [4:0]         cdb_ar_tag0;
    logic [4:0]         cdb_ar_tag1;
    logic [4:0]         cdb_ar_tag2;
    logic [4:0]         cdb_ar_tag3;
    logic [4:0]         cdb_ar_tag4;
    logic [4:0]         cdb_ar_tag5;
    logic [2:0]         cdb_count;

    modport slave (
        input  fu_req, fu_pr_tags, fu_ar_tags,
        output fu_gnt, cdb_broadcast,
        output cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3, cdb_pr_tag4, cdb_pr_tag5,
        output cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3, cdb_ar_tag4, cdb_ar_tag5,
        output cdb_count
    );

    modport master (
        output fu_req, fu_pr_tags, fu_ar_tags,
        input  fu_gnt, cdb_broadcast,
        input  cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3, cdb_pr_tag4, cdb_pr_tag5,
        input  cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3, cdb_ar_tag4, cdb_ar_tag5,
        input  cdb_count
    );
endinterface

// File: rtl/cdb_arb.sv
// Round-robin CDB arbiter: grants up to six requesters per cycle and packs their tags onto lanes 0..n-1.
// Latency: grants are combinational (0 cycles); the CDB lanes are registered (1 cycle).
// Backpressure: none held inside; ungranted requesters keep requesting and retry next cycle.
module cdb_arb #(
    parameter int N_REQ     = 8,
    parameter int CDB_WIDTH = 6
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      recover,
    cdb_arb_if.slave  bus
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     nxt_ptr;
    logic [N_REQ-1:0]     gnt;
    logic [6:0]           req_pr [N_REQ];
    logic [4:0]           req_ar [N_REQ];
    int                   pos [N_REQ];
    int                   rank [N_REQ];
    int                   nxt_cnt;
    int                   last_pos;
    logic [CDB_WIDTH-1:0] nxt_vld;
    logic [6:0]           nxt_pr [CDB_WIDTH];
    logic [4:0]           nxt_ar [CDB_WIDTH];
    logic [CDB_WIDTH-1:0] lane_vld;
    logic [6:0]           lane_pr [CDB_WIDTH];
    logic [4:0]           lane_ar [CDB_WIDTH];
    logic [2:0]           lane_cnt;

    // Split the flat tag buses into per-requester fields.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_pr[g] = bus.fu_pr_tags[7*g +: 7];
        assign req_ar[g] = bus.fu_ar_tags[5*g +: 5];
    end

    // Rank every requester by its distance from rr_ptr; the first CDB_WIDTH requesting ranks win
    // and a winner's rank is directly its lane number, which keeps valid lanes contiguous.
    always_comb begin
        gnt      = '0;
        nxt_cnt  = 0;
        last_pos = -1;
        nxt_ptr  = rr_ptr;
        nxt_vld  = '0;
        for (int l = 0; l < CDB_WIDTH; l++) begin
            nxt_pr[l] = '0;
            nxt_ar[l] = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            pos[i] = i - int'(rr_ptr);
            if (pos[i] < 0) begin
                pos[i] = pos[i] + N_REQ;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            rank[i] = 0;
            for (int j = 0; j < N_REQ; j++) begin
                if (bus.fu_req[j] && (pos[j] < pos[i])) begin
                    rank[i] = rank[i] + 1;
                end
            end
        end
        if (!reset && !recover) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.fu_req[i] && (rank[i] < CDB_WIDTH)) begin
                    gnt[i]  = 1'b1;
                    nxt_cnt = nxt_cnt + 1;
                    // The furthest winner from rr_ptr sets where priority starts next cycle.
                    if (pos[i] > last_pos) begin
                        last_pos = pos[i];
                        nxt_ptr  = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
                    end
                end
            end
            for (int l = 0; l < CDB_WIDTH; l++) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (gnt[i] && (rank[i] == l)) begin
                        nxt_pr[l] = req_pr[i];
                        nxt_ar[l] = req_ar[i];
                    end
                end
                nxt_vld[l] = (l < nxt_cnt);
            end
        end
    end

    // Register the packed lanes for one cycle and advance the round-robin pointer on any grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr   <= '0;
            lane_vld <= '0;
            lane_cnt <= '0;
            for (int l = 0; l < CDB_WIDTH; l++) begin
                lane_pr[l] <= '0;
                lane_ar[l] <= '0;
            end
        end else begin
            lane_vld <= nxt_vld;
            lane_cnt <= 3'(nxt_cnt);
            for (int l = 0; l < CDB_WIDTH; l++) begin
                lane_pr[l] <= nxt_pr[l];
                lane_ar[l] <= nxt_ar[l];
            end
            if (nxt_cnt != 0) begin
                rr_ptr <= nxt_ptr;
            end
        end
    end

    assign bus.fu_gnt        = gnt;
    assign bus.cdb_broadcast = lane_vld;
    assign bus.cdb_count     = lane_cnt;
    assign bus.cdb_pr_tag0   = lane_pr[0];
    assign bus.cdb_pr_tag1   = lane_pr[1];
    assign bus.cdb_pr_tag2   = lane_pr[2];
    assign bus.cdb_pr_tag3   = lane_pr[3];
    assign bus.cdb_pr_tag4   = lane_pr[4];
    assign bus.cdb_pr_tag5   = lane_pr[5];
    assign bus.cdb_ar_tag0   = lane_ar[0];
    assign bus.cdb_ar_tag1   = lane_ar[1];
    assign bus.cdb_ar_tag2   = lane_ar[2];
    assign bus.cdb_ar_tag3   = lane_ar[3];
    assign bus.cdb_ar_tag4   = lane_ar[4];
    assign bus.cdb_ar_tag5   = lane_ar[5];
endmodule
